matrix_scan_arbiter: RTL and testbench
======================================

Name: matrix_scan_arbiter

Overview:
Owns a double-buffered 8x8 RGB frame store for the LED matrix and drives its row scan (COMM/DATA_R/G/B/EN). Game logic writes whole rows into the back buffer through a req/ack port and requests a buffer swap. The swap happens only at a frame boundary, so a partially drawn frame is never shown. This block replaces the ad-hoc per-row multiplexing in the top level and sits between the game FSM and the matrix pins.

Parameters:
ROW_TICKS, 5000, CLK cycles each row is driven (must be >= 2)
BLANK_TICKS, 8, CLK cycles all colours are forced off between rows (used only with SCAN_BLANK_EN)

Ports:
CLK  in  1  system clock
clear_n  in  1  synchronous active-low reset
wr_req  in  1  row write request; held until wr_ack
wr_row  in  3  target row index
wr_r  in  8  red row data, active-low
wr_g  in  8  green row data, active-low
wr_b  in  8  blue row data, active-low
wr_ack  out  1  one-cycle pulse: write committed to back buffer
swap_req  in  1  one-cycle pulse: present back buffer at next frame boundary
swap_pend  out  1  swap requested, not yet done
swap_done  out  1  one-cycle pulse in the cycle the front/back select toggles
DATA_R  out  8  red row drive, active-low
DATA_G  out  8  green row drive, active-low
DATA_B  out  8  blue row drive, active-low
COMM  out  3  currently driven row index
EN  out  1  matrix enable
frame_tick  out  1  one-cycle pulse when row 7 finishes (frame boundary)

Behaviour:
- Reset (clear_n=0 at posedge CLK): both buffers all 8'hFF; front select=0; row=0; tick=0; state=DRIVE; DATA_*=8'hFF; COMM=0; EN=0; wr_ack=0; swap_pend=0; swap_done=0; frame_tick=0. EN goes to 1 on the first cycle after reset is released.
- Reset mid-operation: aborts any pending swap and any in-flight write. wr_ack is not issued for the aborted write.
- FSM states: DRIVE, BLANK, SWAP.
- DRIVE:
  - COMM=row; DATA_* = front[row], registered, so pins follow the row change by 1 cycle. COMM and DATA update in the same cycle.
  - tick counts 0..ROW_TICKS-1.
  - At terminal count: go to BLANK if BLANK_TICKS>0 under the macro; otherwise advance the row directly.
- BLANK: DATA_*=8'hFF and COMM holds for BLANK_TICKS cycles, then the row advances.
- Row advance:
  - row 0..6: row+1, back to DRIVE.
  - row 7: wrap to 0 and pulse frame_tick. Go to SWAP if swap_pend=1, else DRIVE.
- SWAP: exactly 1 cycle. Toggle front select, pulse swap_done, clear swap_pend, then DRIVE row 0 reading the new front.
- swap_req: sets swap_pend. A repeat request while pending is ignored, giving one swap only. A swap_req in the SWAP cycle itself sets swap_pend again for the next frame.
- Write port:
  - When wr_req=1 and state!=SWAP: the back buffer row wr_row is written with {wr_r,wr_g,wr_b} and wr_ack pulses on the next cycle.
  - The requester drops wr_req in the cycle it sees wr_ack. A write is never repeated while wr_ack=1.
  - In the SWAP state the write stalls one cycle and lands in the new back buffer.
  - Back-to-back writes run at a throughput of 1 per 2 cycles.
- The front buffer is never writable. Writes during scan never affect displayed pixels until a swap.
- tick width: $clog2(ROW_TICKS+BLANK_TICKS). No overflow is permitted.

Optional Feature:
SCAN_BLANK_EN:
- Defined: the BLANK state is inserted after each row for BLANK_TICKS cycles (anti-ghosting); frame period = 8*(ROW_TICKS+BLANK_TICKS) cycles, plus 1 for SWAP.
- Undefined: the BLANK state is absent and BLANK_TICKS is ignored; frame period = 8*ROW_TICKS cycles, plus 1 for SWAP.

Decomposition:
- Shared package matrix_pkg:
  - ROWS=8, COLS=8, ROW_W=3, PIX_OFF=8'hFF.
  - FSM state enum {DRIVE, BLANK, SWAP}.
  - Packed row struct {r,g,b}.
- Sub-module matrix_frame_ram: 2x8 entries of 24 bits, one synchronous write port, one read port, bank select. The top holds the FSM, counters and handshake.

Test Plan:
- Release reset, ROW_TICKS=4, macro off: COMM steps 0..7 every 4 cycles; DATA_*=8'hFF throughout; frame_tick pulses every 32 cycles; EN=1 from cycle 1.
- Write row 3 with r=8'h3F, g=8'hFF, b=8'hFF, with no swap: wr_ack 1 cycle later; DATA_R stays 8'hFF on COMM=3 indefinitely.
- Write all 8 rows, then pulse swap_req mid-frame: swap_pend=1 until the end of row 7; swap_done pulses once; the next COMM=3 shows DATA_R=8'h3F.
- swap_req pulsed 3 times in one frame: exactly one swap_done; swap_pend clears.
- wr_req asserted in the SWAP cycle: wr_ack delayed 1 extra cycle; data appears only after the following swap.
- Macro on, BLANK_TICKS=2, ROW_TICKS=4: DATA_*=8'hFF for 2 cycles between rows; frame_tick period 48 cycles. Assert clear_n=0 mid-frame: all outputs return to reset values next cycle and swap_pend=0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types for the LED matrix frame store and row scan.
// Row data is active-low: a set bit turns the pixel off.
package matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int ROW_W = 3;
  localparam logic [COLS-1:0] PIX_OFF = 8'hFF;

  typedef enum logic [1:0] {
    DRIVE,
    BLANK,
    SWAP
  } state_t;

  typedef struct packed {
    logic [COLS-1:0] r;
    logic [COLS-1:0] g;
    logic [COLS-1:0] b;
  } row_t;

  localparam row_t ROW_OFF = '{
    r: PIX_OFF,
    g: PIX_OFF,
    b: PIX_OFF
  };

endpackage

// File: rtl/matrix_frame_ram.sv
// Two banks of 8 rows x 24 bits; one write port, one async read port.
// Both banks return to all-off on reset.
module matrix_frame_ram
  import matrix_pkg::*;
(
  input  logic             CLK,
  input  logic             clear_n,
  input  logic             we,
  input  logic             wbank,
  input  logic [ROW_W-1:0] waddr,
  input  row_t             wdata,
  input  logic             rbank,
  input  logic [ROW_W-1:0] raddr,
  output row_t             rdata
);

  row_t mem [2][ROWS];

  always_ff @(posedge CLK) begin
    if (!clear_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < ROWS; i++) begin
          mem[b][i] <= ROW_OFF;
        end
      end
    end else if (we) begin
      mem[wbank][waddr] <= wdata;
    end
  end

  assign rdata = mem[rbank][raddr];

endmodule

// File: rtl/matrix_scan_arbiter.sv
// Double-buffered 8x8 RGB matrix scanner with frame-boundary swap.
// Define SCAN_BLANK_EN to insert BLANK_TICKS dark cycles after each row.
module matrix_scan_arbiter
  import matrix_pkg::*;
#(
  parameter int ROW_TICKS   = 5000,
  parameter int BLANK_TICKS = 8
) (
  input  logic             CLK,
  input  logic             clear_n,
  input  logic             wr_req,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_r,
  input  logic [COLS-1:0]  wr_g,
  input  logic [COLS-1:0]  wr_b,
  output logic             wr_ack,
  input  logic             swap_req,
  output logic             swap_pend,
  output logic             swap_done,
  output logic [COLS-1:0]  DATA_R,
  output logic [COLS-1:0]  DATA_G,
  output logic [COLS-1:0]  DATA_B,
  output logic [ROW_W-1:0] COMM,
  output logic             EN,
  output logic             frame_tick
);

  localparam int TW = $clog2(ROW_TICKS + BLANK_TICKS);
  localparam logic [TW-1:0] ROW_LAST = TW'(ROW_TICKS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam bit HAS_BLANK = (BLANK_TICKS > 0);
`endif

  state_t           state, state_n;
  logic [ROW_W-1:0] row, row_n;
  logic [TW-1:0]    tick, tick_n;
  logic             fsel;
  logic             adv;
  logic             frame_last;
  logic             wr_go;
  row_t             rdata;
  row_t             wdata;
  row_t             pins;

  always_comb begin
    state_n = state;
    row_n   = row;
    tick_n  = tick + 1'b1;
    adv     = 1'b0;
    unique case (state)
      DRIVE: begin
        if (tick == ROW_LAST) begin
          tick_n = '0;
`ifdef SCAN_BLANK_EN
          if (HAS_BLANK) state_n = BLANK;
          else adv = 1'b1;
`else
          adv = 1'b1;
`endif
        end
      end
      BLANK: begin
`ifdef SCAN_BLANK_EN
        if (tick == BLANK_LAST) begin
          tick_n = '0;
          adv    = 1'b1;
        end
`else
        tick_n  = '0;
        state_n = DRIVE;
`endif
      end
      SWAP: begin
        tick_n  = '0;
        state_n = DRIVE;
      end
      default: begin
        tick_n  = '0;
        state_n = DRIVE;
      end
    endcase
    if (adv) begin
      row_n   = row + 1'b1;
      state_n = (row == LAST_ROW && swap_pend) ? SWAP : DRIVE;
    end
  end

  assign frame_last = adv && (row == LAST_ROW);
  // Never write in the SWAP cycle so the row lands in the new back bank
  assign wr_go = wr_req && (state != SWAP) && !wr_ack;
  assign wdata = {wr_r, wr_g, wr_b};

  always_ff @(posedge CLK) begin
    if (!clear_n) begin
      state      <= DRIVE;
      row        <= '0;
      tick       <= '0;
      fsel       <= 1'b0;
      swap_pend  <= 1'b0;
      swap_done  <= 1'b0;
      wr_ack     <= 1'b0;
      frame_tick <= 1'b0;
      EN         <= 1'b0;
      COMM       <= '0;
      pins       <= ROW_OFF;
    end else begin
      state      <= state_n;
      row        <= row_n;
      tick       <= tick_n;
      fsel       <= fsel ^ (state == SWAP);
      swap_pend  <= (state == SWAP) ? swap_req : (swap_pend | swap_req);
      swap_done  <= (state == SWAP);
      wr_ack     <= wr_go;
      frame_tick <= frame_last;
      EN         <= 1'b1;
      COMM       <= row;
      pins       <= (state == DRIVE) ? rdata : ROW_OFF;
    end
  end

  assign DATA_R = pins.r;
  assign DATA_G = pins.g;
  assign DATA_B = pins.b;

  matrix_frame_ram u_ram (
    .CLK     (CLK),
    .clear_n (clear_n),
    .we      (wr_go),
    .wbank   (~fsel),
    .waddr   (wr_row),
    .wdata   (wdata),
    .rbank   (fsel),
    .raddr   (row),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
// Scoreboard bench for matrix_scan_arbiter (ROW_TICKS=4, BLANK_TICKS=2).
// Expected acks, swaps and displayed rows are queued and checked by a monitor.
module tb_matrix_scan_arbiter;
  import matrix_pkg::*;

  localparam int T = 4;
`ifdef SCAN_BLANK_EN
  localparam int BT = 2;
`else
  localparam int BT = 0;
`endif
  localparam int P = 8 * (T + BT);

  logic       CLK = 0;
  logic       clear_n, wr_req, swap_req;
  logic [2:0] wr_row;
  logic [7:0] wr_r, wr_g, wr_b;
  logic       wr_ack, swap_pend, swap_done, EN, frame_tick;
  logic [7:0] DATA_R, DATA_G, DATA_B;
  logic [2:0] COMM;

  matrix_scan_arbiter #(.ROW_TICKS(T), .BLANK_TICKS(2)) dut (
    .CLK(CLK), .clear_n(clear_n), .wr_req(wr_req), .wr_row(wr_row),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .wr_ack(wr_ack),
    .swap_req(swap_req), .swap_pend(swap_pend), .swap_done(swap_done),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B), .COMM(COMM),
    .EN(EN), .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] row;
    logic [23:0] rgb;
  } disp_t;

  int    ack_q[$];
  int    swap_q[$];
  disp_t disp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic [7:0] tr [8] = '{8'hFE, 8'hFD, 8'hFB, 8'h3F, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] tg [8] = '{8'h80, 8'h81, 8'h82, 8'hFF, 8'h84, 8'h85, 8'h86, 8'h87};
  logic [7:0] tb_ [8] = '{8'hC0, 8'hC1, 8'hC2, 8'hFF, 8'hC4, 8'hC5, 8'hC6, 8'hC7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_disp(input logic [2:0] r, input logic [23:0] rgb);
    disp_t d;
    d.row = r;
    d.rgb = rgb;
    disp_q.push_back(d);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  int         prev_comm = 0;
  int         seg_start = 0;
  int         last_ft = -1;
  bit         swap_seen = 0;
  always @(negedge CLK) begin
    if (!clear_n) begin
      prev_comm = 0;
      seg_start = cyc;
      last_ft   = -1;
      swap_seen = 0;
    end else begin
      if (wr_ack) begin
        if (ack_q.size() == 0) chk("unexpected_ack", ack_q.size(), 1);
        else chk("ack_cycle", cyc, ack_q.pop_front());
      end
      if (swap_done) begin
        if (swap_q.size() == 0) chk("unexpected_swap", swap_q.size(), 1);
        else begin
          void'(swap_q.pop_front());
          chk("swap_after_ft", cyc, last_ft + 1);
        end
        swap_seen = 1;
      end
      if (frame_tick) begin
        if (last_ft >= 0) chk("frame_period", cyc - last_ft, swap_seen ? P + 1 : P);
        swap_seen = 0;
        last_ft = cyc;
      end
      if (int'(COMM) != prev_comm) begin
        if (COMM >= 2 && int'(COMM) == prev_comm + 1)
          chk("row_period", cyc - seg_start, T + BT);
        if (disp_q.size() > 0 && disp_q[0].row == COMM) begin
          chk($sformatf("row%0d_data", COMM), {DATA_R, DATA_G, DATA_B}, disp_q[0].rgb);
          void'(disp_q.pop_front());
        end
        prev_comm = int'(COMM);
        seg_start = cyc;
      end
`ifdef SCAN_BLANK_EN
      else if (COMM != 0 && cyc - seg_start >= T)
        chk("blank_data", {DATA_R, DATA_G, DATA_B}, 24'hFFFFFF);
`endif
    end
  end

  task automatic write_row(input logic [2:0] r, input logic [7:0] dr, input logic [7:0] dg,
                           input logic [7:0] db, input int lat);
    wr_row = r; wr_r = dr; wr_g = dg; wr_b = db;
    wr_req = 1;
    ack_q.push_back(cyc + lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (wr_ack) break;
    end
    wr_req = 0;
  endtask

  task automatic pulse_swap();
    swap_req = 1;
    @(negedge CLK);
    swap_req = 0;
  endtask

  task automatic wait_ft();
    bit seen = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge CLK);
      if (frame_tick) begin seen = 1; break; end
    end
    if (!seen) chk("ft_timeout", seen, 1);
  endtask

  task automatic wait_sd();
    bit seen = 0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge CLK);
      if (swap_done) begin seen = 1; break; end
    end
    if (!seen) chk("swap_timeout", seen, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * P && disp_q.size() > 0; i++) @(negedge CLK);
    chk("display_drain", disp_q.size(), 0);
  endtask

  initial begin
    clear_n = 0; wr_req = 0; swap_req = 0;
    wr_row = 0; wr_r = 0; wr_g = 0; wr_b = 0;
    repeat (3) @(negedge CLK);
    chk("rst_comm", COMM, 0);
    chk("rst_data", {DATA_R, DATA_G, DATA_B}, 24'hFFFFFF);
    chk("rst_ctl", {EN, wr_ack, swap_pend, swap_done, frame_tick}, 5'b0);
    for (int r = 1; r < 8; r++) push_disp(3'(r), 24'hFFFFFF);
    clear_n = 1;
    @(negedge CLK);
    chk("en_after_release", EN, 1);
    wait_ft(); wait_ft();
    drain();

    // Write into back buffer without swapping: display unchanged
    write_row(3, 8'h3F, 8'hFF, 8'hFF, 1);
    @(negedge CLK);
    push_disp(3, 24'hFFFFFF); drain();
    push_disp(3, 24'hFFFFFF); drain();

    // Fill all rows, swap mid-frame
    for (int i = 0; i < 8; i++) begin
      write_row(3'(i), tr[i], tg[i], tb_[i], 1);
      @(negedge CLK);
    end
    wait_ft(); repeat (10) @(negedge CLK);
    pulse_swap();
    chk("pend_after_req", swap_pend, 1);
    swap_q.push_back(1);
    wait_ft();
    chk("pend_at_boundary", swap_pend, 1);
    wait_sd();
    chk("pend_after_swap", swap_pend, 0);
    for (int r = 1; r < 8; r++) push_disp(3'(r), {tr[r], tg[r], tb_[r]});
    drain();

    // Three requests in one frame give one swap
    wait_ft();
    repeat (3) begin
      repeat (3) @(negedge CLK);
      pulse_swap();
    end
    swap_q.push_back(1);
    wait_sd();
    wait_ft(); wait_ft();
    chk("pend_after_multi", swap_pend, 0);
    for (int r = 1; r < 8; r++) push_disp(3'(r), 24'hFFFFFF);
    drain();

    // Write issued in the SWAP cycle stalls and lands in the new back bank
    wait_ft(); repeat (10) @(negedge CLK);
    pulse_swap();
    swap_q.push_back(1);
    wait_ft();
    write_row(5, 8'h12, 8'h34, 8'h56, 2);
    push_disp(3, {tr[3], tg[3], tb_[3]});
    push_disp(5, {tr[5], tg[5], tb_[5]});
    drain();
    wait_ft(); repeat (10) @(negedge CLK);
    pulse_swap();
    swap_q.push_back(1);
    wait_sd();
    push_disp(3, 24'hFFFFFF);
    push_disp(5, 24'h123456);
    drain();

    // Reset mid-frame aborts pending swap and in-flight write
    wait_ft(); repeat (5) @(negedge CLK);
    pulse_swap();
    repeat (3) @(negedge CLK);
    clear_n = 0;
    wr_req = 1; wr_row = 2; wr_r = 8'h00; wr_g = 8'h00; wr_b = 8'h00;
    @(negedge CLK);
    chk("midrst_comm", COMM, 0);
    chk("midrst_data", {DATA_R, DATA_G, DATA_B}, 24'hFFFFFF);
    chk("midrst_ctl", {EN, wr_ack, swap_pend, swap_done, frame_tick}, 5'b0);
    wr_req = 0;
    @(negedge CLK);
    clear_n = 1;
    @(negedge CLK);
    chk("en_after_midrst", EN, 1);
    push_disp(2, 24'hFFFFFF);
    push_disp(5, 24'hFFFFFF);
    drain();
    wait_ft(); wait_ft();

    chk("ack_q_empty", ack_q.size(), 0);
    chk("swap_q_empty", swap_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
